gpu_launch_ctrl: RTL and testbench

GPU_LAUNCH_CTRL -- requirements
Module: gpu_launch_ctrl

---
 rtl/e_gpu_pkg.sv | 17 +
 rtl/gpu_launch_ctrl_sat_counter.sv | 28 ++
 rtl/gpu_launch_ctrl.sv | 108 ++++++++++
 tb/tb_gpu_launch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/e_gpu_pkg.sv
// Shared definitions for the GPU launch controller: FSM states, counter width
// and default parameter values.
package e_gpu_pkg;

  localparam int CNT_W           = 32;
  localparam int DEF_NUM_CORES   = 4;
  localparam int DEF_ACK_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4
  } launch_state_e;

endpackage

// File: rtl/gpu_launch_ctrl_sat_counter.sv
// Saturating up-counter: clear has priority, holds at all-ones instead of wrapping.
module sat_counter
  import e_gpu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         enable_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/gpu_launch_ctrl.sv
// Launch controller: turns a start-level rising edge into a one-cycle core launch
// pulse, waits for the cores to report busy, then for all of them to go idle.
module gpu_launch_ctrl
  import e_gpu_pkg::*;
#(
  parameter int NUM_CORES   = DEF_NUM_CORES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 gpu_start_i,
  input  logic [NUM_CORES-1:0] core_busy_i,
  output logic [NUM_CORES-1:0] core_start_o,
  output logic                 gpu_busy_o,
  output logic                 gpu_done_o,
  output logic                 timeout_o,
  output logic [CNT_W-1:0]     cycle_cnt_o
);

  localparam int               ACK_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  logic [NUM_CORES-1:0] busy_meta_q, busy_sync_q;
  logic                 start_prev_q, start_armed_q, start_rise, any_busy;
  launch_state_e        state_q, state_d;
  logic [ACK_W-1:0]     ack_cnt_q, ack_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 cnt_clear, cnt_enable;

  // Handshake: the launch pulse is the request; any synchronised busy bit is the
  // acknowledge, and all synchronised busy bits low afterwards is completion.
  // start_armed_q blocks a launch until start has been seen low after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_meta_q   <= '0;
      busy_sync_q   <= '0;
      start_prev_q  <= 1'b0;
      start_armed_q <= 1'b0;
    end else begin
      busy_meta_q  <= core_busy_i;
      busy_sync_q  <= busy_meta_q;
      start_prev_q <= gpu_start_i;
      if (!gpu_start_i) start_armed_q <= 1'b1;
    end
  end

  assign start_rise = gpu_start_i & ~start_prev_q & start_armed_q;
  assign any_busy   = |busy_sync_q;

  always_comb begin
    state_d   = state_q;
    ack_cnt_d = '0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE:     if (start_rise) state_d = ST_LAUNCH;
      ST_LAUNCH:   state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (any_busy) begin
          state_d = ST_RUN;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      ST_RUN:      if (!any_busy) state_d = ST_DONE;
      ST_DONE: begin
        if (gpu_start_i) timeout_d = timeout_q;
        else             state_d   = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ack_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Clearing on the IDLE->LAUNCH transition makes the count read 0 during LAUNCH.
  assign cnt_clear  = (state_q == ST_IDLE) && start_rise;
  assign cnt_enable = (state_q == ST_WAIT_ACK) || (state_q == ST_RUN);

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (cnt_clear),
    .enable_i(cnt_enable),
    .count_o (cycle_cnt_o)
  );

  assign core_start_o = {NUM_CORES{state_q == ST_LAUNCH}};
  assign gpu_busy_o   = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_ACK) ||
                        (state_q == ST_RUN);
  assign gpu_done_o   = (state_q == ST_DONE);
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_gpu_launch_ctrl.sv
// Bench for gpu_launch_ctrl: directed runs with hand-computed launch and
// completion records queued up front and checked by a negedge monitor.
module tb_gpu_launch_ctrl;
  import e_gpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        gpu_start_i;
  logic [3:0]  core_busy_i;
  logic [3:0]  core_start_o;
  logic        gpu_busy_o;
  logic        gpu_done_o;
  logic        timeout_o;
  logic [31:0] cycle_cnt_o;

  int          n_total = 0;
  int          n_bad   = 0;
  int          low_cnt;
  logic        done_prev = 1'b0;
  logic [3:0]  start_exp;
  logic [32:0] done_exp;

  logic [3:0]  start_exp_q[$];
  logic [32:0] done_exp_q[$];

  gpu_launch_ctrl #(
    .NUM_CORES  (4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .gpu_start_i (gpu_start_i),
    .core_busy_i (core_busy_i),
    .core_start_o(core_start_o),
    .gpu_busy_o  (gpu_busy_o),
    .gpu_done_o  (gpu_done_o),
    .timeout_o   (timeout_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic launch();
    start_exp_q.push_back(4'hF);
    gpu_start_i = 1'b1;
  endtask

  task automatic expect_done(input logic tmo, input logic [31:0] cnt);
    done_exp_q.push_back({tmo, cnt});
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!gpu_done_o && k < 200) begin
      cyc(1);
      k++;
    end
    check({name, "_done_seen"}, gpu_done_o, 1);
  endtask

  task automatic end_run(input string name, input logic [31:0] cnt);
    gpu_start_i = 1'b0;
    cyc(2);
    check({name, "_idle_done"}, gpu_done_o, 0);
    check({name, "_idle_timeout"}, timeout_o, 0);
    check({name, "_idle_busy"}, gpu_busy_o, 0);
    check({name, "_idle_cnt_hold"}, cycle_cnt_o, cnt);
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_i);
      if (core_start_o != 4'h0) begin
        if (start_exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL start_pulse act=%0h req=no_pulse", core_start_o);
        end else begin
          start_exp = start_exp_q.pop_front();
          check("start_pulse", core_start_o, start_exp);
        end
      end
      if (gpu_done_o && !done_prev) begin
        if (done_exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL done_rise act=1 req=no_done");
        end else begin
          done_exp = done_exp_q.pop_front();
          check("done_timeout", timeout_o, done_exp[32]);
          check("done_cnt", cycle_cnt_o, done_exp[31:0]);
          check("done_busy", gpu_busy_o, 0);
        end
      end
      done_prev = gpu_done_o;
    end
  end

  // stimulus
  initial begin
    rst_ni      = 1'b0;
    gpu_start_i = 1'b0;
    core_busy_i = 4'h0;
    cyc(2);
    check("rst_start", core_start_o, 0);
    check("rst_busy", gpu_busy_o, 0);
    check("rst_done", gpu_done_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_cnt", cycle_cnt_o, 0);
    rst_ni = 1'b1;
    cyc(2);

    // normal run: 4 WAIT_ACK + 10 RUN cycles
    launch();
    expect_done(1'b0, 32'd14);
    cyc(3);
    check("normal_busy_wait", gpu_busy_o, 1);
    check("normal_cnt_wait", cycle_cnt_o, 1);
    core_busy_i = 4'hF;
    cyc(10);
    core_busy_i = 4'h0;
    wait_done("normal");
    end_run("normal", 32'd14);

    // timeout, then level hold for 100 cycles and a second edge
    launch();
    expect_done(1'b1, 32'd16);
    wait_done("timeout");
    low_cnt = 0;
    repeat (100) begin
      cyc(1);
      if (!gpu_done_o) low_cnt++;
    end
    check("hold_done_low_cycles", low_cnt, 0);
    check("hold_timeout", timeout_o, 1);
    gpu_start_i = 1'b0;
    cyc(2);
    check("hold_release_done", gpu_done_o, 0);
    launch();
    expect_done(1'b1, 32'd16);
    wait_done("relaunch");
    end_run("relaunch", 32'd16);

    // single-cycle busy: ack wins, RUN for one cycle, then DONE
    launch();
    expect_done(1'b0, 32'd5);
    cyc(1);
    check("launch_cnt_clear", cycle_cnt_o, 0);
    check("launch_busy", gpu_busy_o, 1);
    cyc(2);
    core_busy_i = 4'hF;
    cyc(1);
    core_busy_i = 4'h0;
    wait_done("blip");
    end_run("blip", 32'd5);

    // partial busy with overlapping bits; start toggled mid-run is ignored
    launch();
    expect_done(1'b0, 32'd13);
    cyc(3);
    core_busy_i = 4'h1;
    cyc(3);
    core_busy_i = 4'h9;
    cyc(1);
    gpu_start_i = 1'b0;
    cyc(1);
    gpu_start_i = 1'b1;
    cyc(1);
    core_busy_i = 4'h8;
    cyc(2);
    check("partial_run_busy", gpu_busy_o, 1);
    check("partial_run_done", gpu_done_o, 0);
    cyc(1);
    core_busy_i = 4'h0;
    wait_done("partial");
    end_run("partial", 32'd13);

    // mid-run reset with start held high afterwards
    launch();
    cyc(3);
    core_busy_i = 4'h3;
    cyc(4);
    check("midrst_pre_busy", gpu_busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_start", core_start_o, 0);
    check("midrst_busy", gpu_busy_o, 0);
    check("midrst_done", gpu_done_o, 0);
    check("midrst_timeout", timeout_o, 0);
    check("midrst_cnt", cycle_cnt_o, 0);
    cyc(1);
    rst_ni = 1'b1;
    cyc(20);
    check("postrst_busy", gpu_busy_o, 0);
    check("postrst_cnt", cycle_cnt_o, 0);
    core_busy_i = 4'h0;
    gpu_start_i = 1'b0;
    cyc(2);

    // saturation: counter forced near the top while in RUN
    launch();
    expect_done(1'b0, 32'hFFFF_FFFF);
    cyc(3);
    core_busy_i = 4'hF;
    cyc(4);
    force dut.u_cycle_cnt.count_q = 32'hFFFF_FFFE;
    @(posedge clk_i);
    #1 release dut.u_cycle_cnt.count_q;
    cyc(3);
    check("sat_cnt_a", cycle_cnt_o, 32'hFFFF_FFFF);
    cyc(3);
    check("sat_cnt_b", cycle_cnt_o, 32'hFFFF_FFFF);
    check("sat_busy", gpu_busy_o, 1);
    core_busy_i = 4'h0;
    wait_done("sat");
    end_run("sat", 32'hFFFF_FFFF);

    // final report
    cyc(3);
    check("start_q_left", start_exp_q.size(), 0);
    check("done_q_left", done_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
